// File: rtl/shift_counter_gen.sv
// rtl/shift_counter_gen.sv - Johnson / one-hot ring counter with prescaled stepping, phase, tick, wrap
// Optional illegal-state self-correction: define SHIFT_COUNTER_SELFCORR_EN.
module shift_counter_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 2097152,
    localparam int PW   = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    phase,
    output logic             tick,
    output logic             wrap,
    output logic             err
);

    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] RING_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [PSW-1:0]   presc;
    logic             mode_q;
    logic             step;
    logic             mode_chg;
    logic             illegal;
    logic [WIDTH-1:0] shifted;
    logic [PW-1:0]    phase_max;
    logic [PW-1:0]    phase_nxt;
    logic             wrap_nxt;

    assign step     = en && (presc == PSW'(DIV - 1));
    assign mode_chg = (mode != mode_q);

    always_comb begin
        shifted   = out;
        phase_max = mode_q ? PW'(WIDTH - 1) : PW'(2*WIDTH - 1);
        phase_nxt = phase;
        wrap_nxt  = 1'b0;
        case ({mode_q, dir})
            2'b00:   shifted = {out[WIDTH-2:0], ~out[WIDTH-1]};
            2'b01:   shifted = {~out[0], out[WIDTH-1:1]};
            2'b10:   shifted = {out[WIDTH-2:0], out[WIDTH-1]};
            default: shifted = {out[0], out[WIDTH-1:1]};
        endcase
        if (!dir) begin
            wrap_nxt  = (phase == phase_max);
            phase_nxt = wrap_nxt ? '0 : phase + PW'(1);
        end else begin
            wrap_nxt  = (phase == '0);
            phase_nxt = wrap_nxt ? phase_max : phase - PW'(1);
        end
    end

`ifdef SHIFT_COUNTER_SELFCORR_EN
    // A legal Johnson word has at most one 0/1 boundary along its (non-circular) length.
    always_comb begin
        int trans;
        trans = 0;
        for (int i = 0; i < WIDTH-1; i++) begin
            if (out[i] != out[i+1]) trans = trans + 1;
        end
        illegal = mode_q ? ($countones(out) != 1) : (trans > 1);
    end
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out    <= '0;
            phase  <= '0;
            tick   <= 1'b0;
            wrap   <= 1'b0;
            err    <= 1'b0;
            presc  <= '0;
            mode_q <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            err  <= 1'b0;
            if (clr) begin
                out    <= mode ? RING_SEED : '0;
                phase  <= '0;
                presc  <= '0;
                mode_q <= mode;
            end else if (en) begin
                presc <= step ? '0 : presc + PSW'(1);
                if (step) begin
                    tick <= 1'b1;
                    if (mode_chg) begin
                        out    <= mode ? RING_SEED : '0;
                        phase  <= '0;
                        mode_q <= mode;
                    end else if (illegal) begin
                        out   <= mode_q ? RING_SEED : '0;
                        phase <= '0;
                        err   <= 1'b1;
                    end else begin
                        out   <= shifted;
                        phase <= phase_nxt;
                        wrap  <= wrap_nxt;
                    end
                end
            end
        end
    end

endmodule
